dht_reader: RTL

Single-wire DHT22 sensor reader: periodically issues the host start pulse, times the sensor's response and 40 data bits, and presents the captured frame as a 40-bit word. Sits directly upstream of the I2C slave, driving its 40-bit `regdata` input (bits 39:24 humidity, 23:8 temperature, 7:0 checksum) so the I2C master always reads the latest good frame.

---
 rtl/dht_reader.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht_reader.sv
// DHT22 single-wire poller: start pulse, response/bit timing, 40-bit frame capture.
// Optional checksum verification of the captured frame is enabled by defining DHT_CHECKSUM_EN.
module dht_reader #(
   parameter int CLK_HZ     = 50000000,
   parameter int POLL_MS    = 2000,
   parameter int START_US   = 1100,
   parameter int BIT1_US    = 48,
   parameter int TIMEOUT_US = 200
) (
   input  logic        CLCK,
   input  logic        RESETn,
   inout  wire         DHT,
   output logic [39:0] regdata,
   output logic        valid,
   output logic        error,
   output logic        busy
);

   localparam int          DIV        = CLK_HZ / 1000000;
   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [15:0] POLL_LAST  = 16'(POLL_MS - 1);
   localparam logic [15:0] START_LAST = 16'(START_US - 1);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_US - 1);
   localparam logic [15:0] BIT1_TH    = 16'(BIT1_US);
   localparam logic [15:0] MS_LAST    = 16'd999;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      RELEASE   = 3'd2,
      RESP_LOW  = 3'd3,
      RESP_HIGH = 3'd4,
      BIT_LOW   = 3'd5,
      BIT_HIGH  = 3'd6,
      CHECK     = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] us_q, us_d;
   logic [15:0] ms_q, ms_d;
   logic [5:0]  bits_q, bits_d;
   logic [39:0] shift_q, shift_d;
   logic [39:0] regdata_q, regdata_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic        busy_q, busy_d;
   logic        drive_q, drive_d;
   logic [2:0]  sync_q;

   logic        tick_s;
   logic        rise_s;
   logic        fall_s;
   logic        timeout_s;
   logic [15:0] us_next_s;

`ifdef DHT_CHECKSUM_EN
   function automatic logic [7:0] frame_sum(input logic [39:0] f);
      frame_sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
   endfunction
`endif

   // Two-flop synchroniser plus one history flop for edge detection; idles high.
   always_ff @(posedge CLCK or negedge RESETn) begin
      if (!RESETn) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[1:0], DHT};
      end
   end

   assign rise_s = sync_q[1] & ~sync_q[2];
   assign fall_s = ~sync_q[1] & sync_q[2];

   // State, timing counters, frame capture and registered outputs.
   always_ff @(posedge CLCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q   <= IDLE;
         presc_q   <= 16'd0;
         us_q      <= 16'd0;
         ms_q      <= 16'd0;
         bits_q    <= 6'd0;
         shift_q   <= 40'd0;
         regdata_q <= 40'd0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
         drive_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         us_q      <= us_d;
         ms_q      <= ms_d;
         bits_q    <= bits_d;
         shift_q   <= shift_d;
         regdata_q <= regdata_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         busy_q    <= busy_d;
         drive_q   <= drive_d;
      end
   end

   // Next-state logic; us_next_s includes the current cycle's tick so durations are exact.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      us_d      = us_q;
      ms_d      = ms_q;
      bits_d    = bits_q;
      shift_d   = shift_q;
      regdata_d = regdata_q;
      valid_d   = valid_q;
      error_d   = error_q;
      tick_s    = (presc_q == DIV_LAST);

      if (tick_s) begin
         presc_d   = 16'd0;
         us_next_s = us_q + 16'd1;
      end else begin
         presc_d   = presc_q + 16'd1;
         us_next_s = us_q;
      end
      us_d      = us_next_s;
      timeout_s = tick_s && (us_q == TMO_LAST);

      case (state_q)
         IDLE: begin
            if (tick_s && (us_q == MS_LAST)) begin
               us_d = 16'd0;
               if (ms_q == POLL_LAST) begin
                  state_d = START;
               end else begin
                  ms_d = ms_q + 16'd1;
               end
            end else begin
               ms_d = ms_q;
            end
         end
         START: begin
            bits_d = 6'd0;
            if (tick_s && (us_q == START_LAST)) begin
               state_d = RELEASE;
            end else begin
               state_d = START;
            end
         end
         RELEASE, RESP_HIGH: begin
            if (fall_s) begin
               state_d = (state_q == RELEASE) ? RESP_LOW : BIT_LOW;
            end else if (timeout_s) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         RESP_LOW, BIT_LOW: begin
            if (rise_s) begin
               state_d = (state_q == RESP_LOW) ? RESP_HIGH : BIT_HIGH;
            end else if (timeout_s) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         BIT_HIGH: begin
            if (fall_s) begin
               shift_d = {shift_q[38:0], (us_next_s >= BIT1_TH)};
               bits_d  = bits_q + 6'd1;
               state_d = (bits_q == 6'd39) ? CHECK : BIT_LOW;
            end else if (timeout_s) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else begin
               state_d = BIT_HIGH;
            end
         end
         CHECK: begin
            state_d = IDLE;
`ifdef DHT_CHECKSUM_EN
            if (frame_sum(shift_q) == shift_q[7:0]) begin
               regdata_d = shift_q;
               valid_d   = 1'b1;
               error_d   = 1'b0;
            end else begin
               error_d   = 1'b1;
            end
`else
            regdata_d = shift_q;
            valid_d   = 1'b1;
            error_d   = 1'b0;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every state change restarts the prescaler too, so each phase is timed from its own start.
      if (state_d != state_q) begin
         presc_d = 16'd0;
         us_d    = 16'd0;
         ms_d    = 16'd0;
      end else begin
         ms_d    = ms_d;
      end

      busy_d  = (state_d != IDLE);
      drive_d = (state_d == START);
   end

   assign DHT     = drive_q ? 1'b0 : 1'bz;
   assign regdata = regdata_q;
   assign valid   = valid_q;
   assign error   = error_q;
   assign busy    = busy_q;

endmodule
